// File: rtl/repeater_arb_pkg.sv
// Shared types and helpers for the repeater link arbiter.
// The optional per-requester flit counters are enabled by defining REPEATER_ARB_STATS_EN.
package repeater_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int STAT_W = 32;

    // Modulo-n increment; explicit compare keeps non-power-of-2 n correct.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/repeater_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NUM_REQ.
module repeater_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any_req
);

    int                 cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;

    // rot_req[k] is the request seen k steps after ptr in the scan order.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign cand_idx[gi] = (int'(ptr) + gi >= NUM_REQ) ? int'(ptr) + gi - NUM_REQ
                                                              : int'(ptr) + gi;
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        logic found;
        found      = 1'b0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_req    = |req;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_req[k]) begin
                found                    = 1'b1;
                gnt_idx                  = SRC_W'(cand_idx[k]);
                gnt_onehot[cand_idx[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/repeater_link_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered valid/ready repeater link.
// Define REPEATER_ARB_STATS_EN to build the per-requester accepted-flit counters.
module repeater_link_arbiter
    import repeater_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_val,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_dat,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            in_rdy,
    output logic                          out_val,
    output logic [DATA_WIDTH-1:0]         out_dat,
    output logic                          out_last,
    output logic [SRC_W-1:0]              out_src,
    input  logic                          out_rdy,
    output logic                          busy,
    output logic [NUM_REQ*STAT_W-1:0]     flit_cnt
);

    arb_state_t state_reg, state_next;
    logic [SRC_W-1:0] owner_reg, owner_next;
    logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic                  out_val_reg;
    logic [DATA_WIDTH-1:0] out_dat_reg;
    logic                  out_last_reg;
    logic [SRC_W-1:0]      out_src_reg;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [SRC_W-1:0]      pick_idx;
    logic                  pick_any;

    logic [NUM_REQ-1:0]    owner_onehot;
    logic [DATA_WIDTH-1:0] dat_arr [NUM_REQ];
    logic                  slot_free;
    logic                  xfer;
    logic [SRC_W-1:0]      xfer_idx;
    logic                  xfer_last;

    repeater_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req        (in_val),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any_req    (pick_any)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
            assign owner_onehot[gi] = (owner_reg == SRC_W'(gi));
            assign dat_arr[gi]      = in_dat[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A new flit may enter whenever the output register is empty or draining this cycle.
    assign slot_free = ~out_val_reg | out_rdy;
    assign xfer      = |(in_val & in_rdy);
    assign xfer_idx  = (state_reg == ARB_IDLE) ? pick_idx : owner_reg;
    assign xfer_last = in_last[xfer_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ARB_IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        if (xfer) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (xfer_last) begin
                        rr_ptr_next = SRC_W'(rr_next(int'(pick_idx), NUM_REQ));
                    end else begin
                        state_next = ARB_LOCKED;
                        owner_next = pick_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer_last) begin
                        state_next  = ARB_IDLE;
                        rr_ptr_next = SRC_W'(rr_next(int'(owner_reg), NUM_REQ));
                    end
                end
                default: state_next = ARB_IDLE;
            endcase
        end
    end

    // While locked only the owner is offered the slot, even if it has dropped in_val.
    always_comb begin
        in_rdy = '0;
        busy   = (state_reg == ARB_LOCKED);
        if (state_reg == ARB_IDLE) begin
            in_rdy = pick_any ? (pick_onehot & {NUM_REQ{slot_free}}) : '0;
        end else begin
            in_rdy = owner_onehot & {NUM_REQ{slot_free}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_reg  <= 1'b0;
            out_dat_reg  <= '0;
            out_last_reg <= 1'b0;
            out_src_reg  <= '0;
        end else if (xfer) begin
            out_val_reg  <= 1'b1;
            out_dat_reg  <= dat_arr[xfer_idx];
            out_last_reg <= xfer_last;
            out_src_reg  <= xfer_idx;
        end else if (out_rdy) begin
            out_val_reg  <= 1'b0;
        end
    end

    assign out_val  = out_val_reg;
    assign out_dat  = out_dat_reg;
    assign out_last = out_last_reg;
    assign out_src  = out_src_reg;

`ifdef REPEATER_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [STAT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (in_val[gi] & in_rdy[gi]) begin
                    cnt_reg <= cnt_reg + STAT_W'(1);
                end
            end
            assign flit_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
        end
    endgenerate
`else
    assign flit_cnt = '0;
`endif

endmodule

// File: tb/tb_repeater_link_arbiter.sv
// Directed self-checking bench for repeater_link_arbiter (NUM_REQ=4, DATA_WIDTH=64).
module tb_repeater_link_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_val;
    logic [N*DW-1:0] in_dat;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_rdy;
    logic            out_val;
    logic [DW-1:0]   out_dat;
    logic            out_last;
    logic [1:0]      out_src;
    logic            out_rdy;
    logic            busy;
    logic [N*32-1:0] flit_cnt;

    int checks = 0;
    int errors = 0;

    repeater_link_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SRC_W(2)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_dat(in_dat), .in_last(in_last),
        .in_rdy(in_rdy), .out_val(out_val), .out_dat(out_dat), .out_last(out_last),
        .out_src(out_src), .out_rdy(out_rdy), .busy(busy), .flit_cnt(flit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_val && out_rdy)
            $display("xfer src=%0d dat=%h last=%0d", out_src, out_dat, out_last);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_val = '0; in_last = '0; out_rdy = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_dat = '0;
        do_reset();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got %0b exp 0", out_val); end
        checks++; if (out_dat !== '0) begin errors++; $display("FAIL reset_out_dat got %h exp 0", out_dat); end
        checks++; if (out_last !== 1'b0 || out_src !== 2'd0) begin errors++; $display("FAIL reset_last_src got %0b/%0d exp 0/0", out_last, out_src); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (in_rdy !== 4'b0000) begin errors++; $display("FAIL reset_in_rdy got %b exp 0000", in_rdy); end
        checks++; if (flit_cnt !== '0) begin errors++; $display("FAIL reset_flit_cnt got %h exp 0", flit_cnt); end
    endtask

    task automatic test_single_flit();
        do_reset();
        in_dat[2*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        in_val = 4'b0100; in_last = 4'b0100; out_rdy = 1'b1;
        #1;
        checks++; if (in_rdy !== 4'b0100) begin errors++; $display("FAIL single_in_rdy got %b exp 0100", in_rdy); end
        cyc();
        in_val = 4'b0000;
        #1;
        checks++; if (out_val !== 1'b1 || out_src !== 2'd2 || out_last !== 1'b1) begin errors++; $display("FAIL single_out got val=%0b src=%0d last=%0b exp 1/2/1", out_val, out_src, out_last); end
        checks++; if (out_dat !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL single_dat got %h exp 0123456789abcdef", out_dat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0b exp 0", busy); end
        // rr_ptr must now be 3: with 0,2,3 requesting, 3 wins.
        in_val = 4'b1101; in_last = 4'b1111;
        #1;
        checks++; if (in_rdy !== 4'b1000) begin errors++; $display("FAIL single_rr_ptr in_rdy got %b exp 1000", in_rdy); end
        cyc();
        in_val = 4'b0000;
        #1;
        checks++; if (out_src !== 2'd3) begin errors++; $display("FAIL single_wrap_src got %0d exp 3", out_src); end
        cyc();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL single_drain got %0b exp 0", out_val); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_src;
        do_reset();
        for (int i = 0; i < N; i++) in_dat[i*DW +: DW] = 64'hA000_0000_0000_0000 + 64'(i);
        in_val = 4'b1111; in_last = 4'b1111; out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_src = 2'(k % 4);
            #1;
            checks++; if (in_rdy !== (4'b0001 << exp_src)) begin errors++; $display("FAIL fair_in_rdy[%0d] got %b exp %b", k, in_rdy, 4'b0001 << exp_src); end
            cyc();
            checks++; if (out_val !== 1'b1 || out_src !== exp_src || out_dat !== 64'hA000_0000_0000_0000 + 64'(exp_src)) begin
                errors++; $display("FAIL fair_out[%0d] got val=%0b src=%0d dat=%h exp 1/%0d", k, out_val, out_src, out_dat, exp_src);
            end
        end
        in_val = '0;
        cyc();
    endtask

    task automatic test_lock();
        int busy_cycles;
        do_reset();
        // Single flit from 0 first so rr_ptr=1 and requester 1 wins over the waiting 0.
        in_val = 4'b0001; in_last = 4'b0001; in_dat[0*DW +: DW] = 64'h0;
        cyc();
        busy_cycles = 0;
        in_val = 4'b0011; in_last = 4'b0001;
        for (int f = 0; f < 3; f++) begin
            in_dat[1*DW +: DW] = 64'h1111_0000_0000_0000 + 64'(f);
            if (f == 2) in_last = 4'b0011;
            #1;
            checks++; if (in_rdy !== 4'b0010) begin errors++; $display("FAIL lock_in_rdy[%0d] got %b exp 0010", f, in_rdy); end
            cyc();
            if (busy) busy_cycles++;
            checks++; if (out_src !== 2'd1 || out_last !== (f == 2) || out_dat !== 64'h1111_0000_0000_0000 + 64'(f)) begin
                errors++; $display("FAIL lock_flit[%0d] got src=%0d last=%0b dat=%h exp src=1 last=%0b", f, out_src, out_last, out_dat, f == 2);
            end
        end
        checks++; if (busy_cycles != 2) begin errors++; $display("FAIL lock_busy_cycles got %0d exp 2", busy_cycles); end
        in_val = 4'b0001; in_last = 4'b0001;
        #1;
        checks++; if (in_rdy !== 4'b0001) begin errors++; $display("FAIL lock_next_grant got %b exp 0001", in_rdy); end
        cyc();
        in_val = '0;
        checks++; if (out_src !== 2'd0 || out_val !== 1'b1) begin errors++; $display("FAIL lock_next_src got %0d exp 0", out_src); end
        cyc();
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_val = 4'b0100; in_last = 4'b0000; out_rdy = 1'b1;
        in_dat[2*DW +: DW] = 64'hDEAD_BEEF_0000_0001;
        cyc();
        in_dat[2*DW +: DW] = 64'hDEAD_BEEF_0000_0002;
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in_rdy !== 4'b0000 || out_val !== 1'b1 || out_dat !== 64'hDEAD_BEEF_0000_0001) begin
                errors++; $display("FAIL bp_hold[%0d] got rdy=%b val=%0b dat=%h exp 0000/1/deadbeef00000001", c, in_rdy, out_val, out_dat);
            end
            cyc();
        end
        out_rdy = 1'b1;
        #1;
        checks++; if (in_rdy !== 4'b0100) begin errors++; $display("FAIL bp_release_rdy got %b exp 0100", in_rdy); end
        cyc();
        checks++; if (out_dat !== 64'hDEAD_BEEF_0000_0002 || out_last !== 1'b0) begin errors++; $display("FAIL bp_flit2 got %h exp deadbeef00000002", out_dat); end
        in_dat[2*DW +: DW] = 64'hDEAD_BEEF_0000_0003; in_last = 4'b0100;
        cyc();
        in_val = '0;
        checks++; if (out_dat !== 64'hDEAD_BEEF_0000_0003 || out_last !== 1'b1) begin errors++; $display("FAIL bp_flit3 got %h exp deadbeef00000003", out_dat); end
        cyc();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0b exp 0", out_val); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        in_val = 4'b1000; in_last = 4'b0000;
        cyc();
        checks++; if (busy !== 1'b1 || out_src !== 2'd3) begin errors++; $display("FAIL rstmid_locked got busy=%0b src=%0d exp 1/3", busy, out_src); end
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_val = '0;
        #1;
        checks++; if (busy !== 1'b0 || out_val !== 1'b0) begin errors++; $display("FAIL rstmid_clear got busy=%0b val=%0b exp 0/0", busy, out_val); end
        in_val = 4'b1001; in_last = 4'b1001;
        #1;
        checks++; if (in_rdy !== 4'b0001) begin errors++; $display("FAIL rstmid_rr_ptr got %b exp 0001", in_rdy); end
        cyc();
        in_val = '0;
        cyc();
    endtask

    task automatic test_stats();
        logic [31:0] exp_cnt [N];
        do_reset();
        in_last = 4'b1111;
        in_val = 4'b0100;
        repeat (10) cyc();
        in_val = 4'b0001;
        repeat (7) cyc();
        in_val = '0;
        cyc();
`ifdef REPEATER_ARB_STATS_EN
        exp_cnt = '{32'd7, 32'd0, 32'd10, 32'd0};
`else
        exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        for (int i = 0; i < N; i++) begin
            checks++; if (flit_cnt[i*32 +: 32] !== exp_cnt[i]) begin errors++; $display("FAIL stats_cnt[%0d] got %0d exp %0d", i, flit_cnt[i*32 +: 32], exp_cnt[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; in_val = '0; in_dat = '0; in_last = '0; out_rdy = 1'b1;
        test_reset();
        test_single_flit();
        test_fairness();
        test_lock();
        test_back_pressure();
        test_reset_mid_packet();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
